// File: rtl/hdu_scoreboard.sv
// In-order issue hazard unit: writeback-slot reservation across NPORTS write ports,
// a per-register RAW/WAW scoreboard, execution-unit ready gating and pipeline flush.
module hdu_scoreboard #(
    parameter int DEPTH  = 8,
    parameter int DLY_W  = 3,
    parameter int NPORTS = 2,
    parameter int NREGS  = 32,
    parameter int REG_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [DLY_W-1:0] op_delay,
    input  logic             ins_v,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [REG_W-1:0] rd,
    input  logic             rs1_v,
    input  logic             rs2_v,
    input  logic             rd_v,
    input  logic             add_ready,
    input  logic             mul_ready,
    input  logic             flush,
    output logic             issue_ok,
    output logic             stall,
    output logic             stall_struct,
    output logic             stall_raw,
    output logic             stall_waw,
    output logic             stall_unit,
    output logic             illegal
);

    localparam int SLOT_W = $clog2(NPORTS + 1);
    localparam int CNT_W  = DLY_W + 1;
    localparam logic [SLOT_W-1:0] SLOT_FULL = SLOT_W'(NPORTS);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);

    logic [SLOT_W-1:0] r_slot     [DEPTH];
    logic [CNT_W-1:0]  r_cnt      [NREGS];
    logic [SLOT_W-1:0] w_slot_nxt [DEPTH];
    logic [CNT_W-1:0]  w_cnt_nxt  [NREGS];

    logic              w_cls_add;
    logic              w_cls_mul;
    logic              w_known;
    logic              w_d_nz;
    logic              w_d_ok;
    logic [SLOT_W-1:0] w_slot_d;
    logic              w_struct;
    logic              w_raw;
    logic              w_waw;
    logic              w_unit;
    logic              w_illegal;
    logic              w_stall;
    logic              w_issue;
    logic              w_reserve;
    logic              w_track;
    logic [DLY_W-1:0]  w_d_m1;

    // Hazard evaluation and issue decision for the instruction offered this cycle.
    always_comb begin
        w_cls_add = (opcode >= 6'd6)  && (opcode <= 6'd9);
        w_cls_mul = (opcode >= 6'd10) && (opcode <= 6'd13);
        w_known   = (opcode >= 6'd1)  && (opcode <= 6'd13);
        w_d_nz    = (op_delay != {DLY_W{1'b0}});
        w_d_ok    = ({1'b0, op_delay} < DEPTH_C);
        w_slot_d  = w_d_ok ? r_slot[op_delay] : {SLOT_W{1'b0}};
        w_struct  = w_d_nz && rd_v && (w_slot_d == SLOT_FULL);
        // r_cnt[0] is never written, so r0 reads as always ready.
        w_raw     = (rs1_v && (r_cnt[rs1] != {CNT_W{1'b0}})) ||
                    (rs2_v && (r_cnt[rs2] != {CNT_W{1'b0}}));
        w_waw     = w_d_nz && rd_v && (r_cnt[rd] > {1'b0, op_delay});
        w_unit    = (w_cls_add && !add_ready) || (w_cls_mul && !mul_ready);
        w_illegal = ins_v && ((opcode > 6'd13) || !w_d_ok);
        w_stall   = ins_v && (opcode != 6'd0) && !w_illegal &&
                    (w_struct || w_raw || w_waw || w_unit);
        w_issue   = reset && ins_v && w_known && !w_illegal && !w_stall && !flush;

        issue_ok     = w_issue;
        stall        = reset && w_stall;
        stall_struct = reset && ins_v && w_struct;
        stall_raw    = reset && ins_v && w_raw;
        stall_waw    = reset && ins_v && w_waw;
        stall_unit   = reset && ins_v && w_unit;
        illegal      = reset && w_illegal;
    end

    // Next-state: shift the reservation window, age the scoreboard, record the new issue.
    always_comb begin
        w_reserve = w_issue && rd_v && w_d_nz;
        w_track   = w_reserve && (rd != {REG_W{1'b0}});
        w_d_m1    = op_delay - {{(DLY_W-1){1'b0}}, 1'b1};
        for (int k = 0; k < DEPTH - 1; k++) begin
            w_slot_nxt[k] = r_slot[k+1] +
                ((w_reserve && (w_d_m1 == DLY_W'(k))) ? {{(SLOT_W-1){1'b0}}, 1'b1}
                                                      : {SLOT_W{1'b0}});
        end
        w_slot_nxt[DEPTH-1] = {SLOT_W{1'b0}};
        for (int r = 0; r < NREGS; r++) begin
            if (w_track && (rd == REG_W'(r))) begin
                w_cnt_nxt[r] = {1'b0, op_delay};
            end else if (r_cnt[r] != {CNT_W{1'b0}}) begin
                w_cnt_nxt[r] = r_cnt[r] - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                w_cnt_nxt[r] = {CNT_W{1'b0}};
            end
        end
    end

    // State registers; flush wipes every pending reservation just like reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) r_slot[k] <= {SLOT_W{1'b0}};
            for (int r = 0; r < NREGS; r++) r_cnt[r] <= {CNT_W{1'b0}};
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) r_slot[k] <= {SLOT_W{1'b0}};
            for (int r = 0; r < NREGS; r++) r_cnt[r] <= {CNT_W{1'b0}};
        end else begin
            for (int k = 0; k < DEPTH; k++) r_slot[k] <= w_slot_nxt[k];
            for (int r = 0; r < NREGS; r++) r_cnt[r] <= w_cnt_nxt[r];
        end
    end

endmodule

// File: tb/tb_hdu_scoreboard.sv
// Bench for hdu_scoreboard: directed scenarios with literal expectations, then random
// traffic checked every cycle against a model of absolute writeback/ready times.
module tb_hdu_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [2:0] op_delay;
    logic       ins_v;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_v, rs2_v, rd_v;
    logic       add_ready, mul_ready, flush;
    logic       issue_ok, stall, stall_struct, stall_raw, stall_waw, stall_unit, illegal;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: pending writeback times and per-register ready time, both absolute.
    int wbq[$];
    int rdy[32];
    int now = 0;

    hdu_scoreboard dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op_delay(op_delay), .ins_v(ins_v),
        .rs1(rs1), .rs2(rs2), .rd(rd), .rs1_v(rs1_v), .rs2_v(rs2_v), .rd_v(rd_v),
        .add_ready(add_ready), .mul_ready(mul_ready), .flush(flush),
        .issue_ok(issue_ok), .stall(stall), .stall_struct(stall_struct),
        .stall_raw(stall_raw), .stall_waw(stall_waw), .stall_unit(stall_unit),
        .illegal(illegal)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int m_cnt(input int r);
        if (r == 0) return 0;
        return (rdy[r] > now) ? rdy[r] - now : 0;
    endfunction

    function automatic int m_slot(input int k);
        int n = 0;
        foreach (wbq[i]) if (wbq[i] == now + k) n++;
        return n;
    endfunction

    task automatic cmp_cycle();
        logic [6:0]   exp_o, act_o;
        logic [15:0]  es, as_s;
        logic [127:0] ec, ac;
        int  d;
        bit  st, rw, ww, un, il, stl, iss, known;
        if (!reset) begin
            wbq.delete();
            for (int r = 0; r < 32; r++) rdy[r] = 0;
        end
        d     = int'(op_delay);
        il    = ins_v && (opcode > 13 || d >= 8);
        known = (opcode >= 1) && (opcode <= 13);
        st    = ins_v && d != 0 && rd_v && m_slot(d) == 2;
        rw    = ins_v && ((rs1_v && m_cnt(int'(rs1)) != 0) || (rs2_v && m_cnt(int'(rs2)) != 0));
        ww    = ins_v && d != 0 && rd_v && m_cnt(int'(rd)) > d;
        un    = ins_v && (((opcode >= 6 && opcode <= 9) && !add_ready) ||
                          ((opcode >= 10 && opcode <= 13) && !mul_ready));
        stl   = ins_v && opcode != 0 && !il && (st || rw || ww || un);
        iss   = ins_v && known && !il && !stl && !flush;
        exp_o = reset ? {iss, stl, st, rw, ww, un, il} : 7'd0;
        act_o = {issue_ok, stall, stall_struct, stall_raw, stall_waw, stall_unit, illegal};
        chk("outputs{iss,stall,struct,raw,waw,unit,ill}", act_o, exp_o);
        es = 16'd0; as_s = 16'd0;
        for (int k = 0; k < 8; k++) begin
            es[k*2 +: 2]   = 2'(m_slot(k));
            as_s[k*2 +: 2] = dut.r_slot[k];
        end
        chk("slot_array", as_s, es);
        ec = 128'd0; ac = 128'd0;
        for (int r = 1; r < 32; r++) begin
            ec[r*4 +: 4] = 4'(m_cnt(r));
            ac[r*4 +: 4] = dut.r_cnt[r];
        end
        chk("cnt_array", ac, ec);
        // Advance the model across the coming rising edge.
        if (!reset || flush) begin
            wbq.delete();
            for (int r = 0; r < 32; r++) rdy[r] = 0;
        end else if (iss && rd_v && d != 0) begin
            wbq.push_back(now + d);
            if (rd != 5'd0) rdy[rd] = now + d + 1;
        end
        now++;
        for (int i = wbq.size() - 1; i >= 0; i--) if (wbq[i] < now) wbq.delete(i);
    endtask

    initial forever begin
        @(negedge clk);
        cmp_cycle();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ins_v = 1'b0; opcode = 6'd0; op_delay = 3'd0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        rs1_v = 1'b0; rs2_v = 1'b0; rd_v = 1'b0;
    endtask

    task automatic set_op(input int op, input int d, input int r1, input int r1v,
                          input int rdi, input int rdv);
        ins_v = 1'b1; opcode = 6'(op); op_delay = 3'(d);
        rs1 = 5'(r1); rs1_v = r1v[0]; rs2 = 5'd0; rs2_v = 1'b0;
        rd = 5'(rdi); rd_v = rdv[0];
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; add_ready = 1'b1; mul_ready = 1'b1;
        idle();
        #2;
        chk("reset_outputs", {issue_ok, stall, illegal}, 3'b000);
        repeat (3) step();
        reset = 1'b1;
        step();

        // ALU producer then RAW consumer on r5.
        set_op(1, 3, 0, 0, 5, 1);
        #1 chk("alu_issue", issue_ok, 1'b1);
        step();
        set_op(1, 0, 5, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("raw_stall", {stall_raw, issue_ok}, 2'b10);
            chk("cnt5_countdown", dut.r_cnt[5], 128'(3 - i));
            if (i == 0) chk("slot2_after_issue", dut.r_slot[2], 2'd1);
            step();
        end
        #1 chk("raw_release", {stall_raw, issue_ok}, 2'b01);
        chk("cnt5_ready", dut.r_cnt[5], 4'd0);
        step();

        // Structural: d=4,3,2 back to back fill slot[2].
        set_op(1, 4, 0, 0, 10, 1); #1 chk("struct_op1", issue_ok, 1'b1); step();
        set_op(1, 3, 0, 0, 11, 1); #1 chk("struct_op2", issue_ok, 1'b1); step();
        set_op(1, 2, 0, 0, 12, 1); #1 chk("struct_stall", {stall_struct, issue_ok}, 2'b10); step();
        #1 chk("struct_release", {stall_struct, issue_ok}, 2'b01); step();
        idle(); repeat (8) step();

        // WAW on r7, then rd=0 never stalls.
        set_op(1, 6, 0, 0, 7, 1); #1 chk("waw_first", issue_ok, 1'b1); step();
        set_op(1, 2, 0, 0, 7, 1);
        for (int i = 0; i < 4; i++) begin
            #1 chk("waw_stall", {stall_waw, issue_ok}, 2'b10);
            step();
        end
        #1 chk("waw_release", {stall_waw, issue_ok}, 2'b01); step();
        set_op(1, 2, 0, 0, 0, 1); #1 chk("rd0_no_waw", {stall_waw, issue_ok}, 2'b01); step();

        // Unit gates and illegal opcode.
        set_op(10, 1, 0, 0, 13, 1); mul_ready = 1'b0;
        #1 chk("mul_gate", {stall_unit, stall, issue_ok}, 3'b110); step();
        mul_ready = 1'b1; set_op(6, 1, 0, 0, 14, 1); add_ready = 1'b0;
        #1 chk("add_gate", {stall_unit, stall, issue_ok}, 3'b110); step();
        add_ready = 1'b1; set_op(63, 0, 0, 0, 0, 0);
        #1 chk("illegal_op", {illegal, stall, issue_ok}, 3'b100); step();
        idle(); repeat (8) step();

        // Flush kills the pending r9 reservation and the same-cycle issue.
        set_op(1, 4, 0, 0, 9, 1); #1 chk("flush_producer", issue_ok, 1'b1); step();
        set_op(1, 0, 9, 1, 0, 0); flush = 1'b1;
        #1 chk("flush_kills_issue", issue_ok, 1'b0);
        chk("cnt9_pending", dut.r_cnt[9], 4'd4);
        step();
        flush = 1'b0;
        #1 chk("post_flush_issue", issue_ok, 1'b1);
        chk("cnt9_cleared", dut.r_cnt[9], 4'd0);
        step();

        // Asynchronous reset mid-flight.
        set_op(1, 5, 0, 0, 3, 1); step();
        set_op(1, 2, 0, 0, 4, 1);
        #1 chk("pre_reset_issue", issue_ok, 1'b1);
        #1 reset = 1'b0;
        #1 chk("async_reset_outputs",
               {issue_ok, stall, stall_struct, stall_raw, stall_waw, stall_unit, illegal}, 7'd0);
        chk("async_reset_cnt3", dut.r_cnt[3], 4'd0);
        step(); step();
        reset = 1'b1;
        step();

        // Randomised traffic, checked by the per-cycle compare process.
        for (int n = 0; n < 3000; n++) begin
            int sel;
            sel      = int'($urandom_range(0, 19));
            ins_v    = ($urandom_range(0, 9) < 8);
            opcode   = (sel < 16) ? 6'(sel) : ((sel == 19) ? 6'd63 : 6'(sel - 15));
            op_delay = 3'($urandom_range(0, 7));
            rs1      = 5'($urandom_range(0, 7));
            rs2      = 5'($urandom_range(0, 7));
            rd       = 5'($urandom_range(0, 7));
            rs1_v    = $urandom_range(0, 1) == 1;
            rs2_v    = $urandom_range(0, 2) == 0;
            rd_v     = $urandom_range(0, 3) != 0;
            add_ready = $urandom_range(0, 3) != 0;
            mul_ready = $urandom_range(0, 3) != 0;
            flush    = $urandom_range(0, 24) == 0;
            reset    = $urandom_range(0, 499) != 0;
            step();
        end
        reset = 1'b1; flush = 1'b0; idle();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hdu_scoreboard.md
Name: hdu_scoreboard

Overview:
- Parametrised hazard-detection and issue unit for the in-order issue stage.
- Successor to the single-bit writeback reservation HDU. It adds:
  - a configurable reservation window;
  - NPORTS register-file write ports per cycle, using a per-slot occupancy counter;
  - an internal per-register scoreboard covering RAW and WAW hazards;
  - a mul_ready gate for the multiply class;
  - a pipeline flush.
- Sits between decode and the execution units. Decides each cycle whether the decoded instruction may issue.

Parameters:
- DEPTH, 8, writeback reservation window in cycles; legal op_delay is 0..DEPTH-1.
- DLY_W, 3, op_delay width; must equal clog2(DEPTH).
- NPORTS, 2, register-file write ports, i.e. writebacks accepted per cycle.
- NREGS, 32, architectural registers.
- REG_W, 5, register index width, clog2(NREGS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  decoded opcode.
- op_delay  in  DLY_W  cycles from issue to writeback.
- ins_v  in  1  decoded instruction valid.
- rs1, rs2, rd  in  REG_W  source and destination indices.
- rs1_v, rs2_v, rd_v  in  1  operand-used flags.
- add_ready  in  1  adder unit can accept an operation.
- mul_ready  in  1  multiplier unit can accept an operation.
- flush  in  1  synchronous kill of all pending state.
- issue_ok  out  1  instruction issues this cycle.
- stall  out  1  valid instruction held this cycle.
- stall_struct, stall_raw, stall_waw, stall_unit  out  1 each  stall causes.
- illegal  out  1  opcode or op_delay outside the legal set.

Behaviour:
- State:
  - slot[0..DEPTH-1], each clog2(NPORTS+1) bits; slot[k] = writebacks landing k cycles from now.
  - cnt[1..NREGS-1], each DLY_W+1 bits; cnt[r] = cycles until r is readable, 0 = ready.
  - r0 is never tracked and is always ready.
- Reset (reset low, asynchronous): all slot and cnt values clear to 0. While reset is low, issue_ok, stall, all causes and illegal are 0.
- Opcode classes:
  - 0 = nop: never issues, no stall.
  - 1..5 = ALU, no unit gate.
  - 6..9 = adder class, gated by add_ready.
  - 10..13 = multiplier class, gated by mul_ready.
  - Any other opcode raises illegal when ins_v.
- Combinational hazard checks (d = op_delay):
  - stall_struct: d != 0 && rd_v && slot[d] == NPORTS.
  - stall_raw: (rs1_v && cnt[rs1] != 0) || (rs2_v && cnt[rs2] != 0).
  - stall_waw: d != 0 && rd_v && cnt[rd] > d, which would reorder writebacks.
  - stall_unit: class ready input low.
  - illegal: also raised when d >= DEPTH (only possible when DEPTH is not a power of 2).
- Issue decision:
  - stall = ins_v && opcode != 0 && !illegal && (any cause).
  - issue_ok = ins_v && opcode in 1..13 && !illegal && !stall && !flush.
  - Cause outputs are qualified by ins_v.
- Sequential update, every rising edge:
  - slot[k] <= slot[k+1] for k < DEPTH-1; slot[DEPTH-1] <= 0.
  - If issue_ok && rd_v && d != 0, also slot[d-1] gets +1 relative to the shifted value.
  - cnt[r] <= saturating decrement of cnt[r].
  - If issue_ok && rd_v && rd != 0 && d != 0, then cnt[rd] <= d, overriding the decrement.
- Timing: a producer issued in cycle t with delay d writes back in t+d. A dependent instruction can issue no earlier than t+d+1 (no bypass).
- op_delay = 0: the instruction issues with no reservation and no scoreboard write.
- Same-cycle self-dependence (rs equal to rd) checks the old cnt only.
- flush: at the next edge all slot and cnt values are 0. issue_ok is forced to 0 during the flush cycle. flush has priority over a simultaneous issue.
- A slot counter can never exceed NPORTS; the structural check guarantees this. The verification bench asserts it.
- Reset asserted mid-operation clears everything immediately, regardless of pending writebacks.

Test Plan:
- Reset release, then ALU op opcode=1, d=3, rd=5, ins_v=1 -> issue_ok=1. cnt[5] is 3,2,1,0 over the next 4 edges. slot[2] is 1 after the first edge.
- RAW: after the above, opcode=1, rs1=5 offered every cycle -> stall_raw=1 for 3 cycles, then issue_ok=1 in cycle t+4.
- Structural, NPORTS=2: three back-to-back ops, d=4, 3, 2, distinct rd -> the first two issue. The third has slot[2]=2, so stall_struct=1 for exactly 1 cycle.
- WAW: issue rd=7 d=6, next cycle rd=7 d=2 -> stall_waw=1 until cnt[7] <= 2, then issue. rd=0 never stalls.
- Unit gates: opcode=10 with mul_ready=0 -> stall_unit=1, issue_ok=0. opcode=63 -> illegal=1, issue_ok=0, stall=0.
- flush with ins_v=1 and a pending cnt[9]=4 -> issue_ok=0 that cycle. Next cycle all slot and cnt are 0, and rs1=9 issues. Async reset low mid-flight -> outputs 0 immediately.
